// File: rtl/breath_pwm.sv
// breath_pwm: turns a BITS-wide duty value into a registered PWM LED drive.
// The period is MAX = 2^BITS-1 ticks, and each tick is PRESCALE clk cycles.
// Duty is latched only at the period wrap, so the LED never glitches
// when the upstream counter changes mid-period.
// Parameter assumptions: BITS >= 2, PRESCALE >= 1.
module breath_pwm #(
  parameter int unsigned BITS     = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] duty,
  output logic            out,
  output logic            period_start
);

  localparam int unsigned MAX = (1 << BITS) - 1;
  localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]   pre;
  logic [PW-1:0]   pre_d;
  logic [BITS-1:0] phase;
  logic [BITS-1:0] phase_d;
  logic [BITS-1:0] duty_q;
  logic [BITS-1:0] duty_q_d;
  logic            tick;
  logic            wrap;
  logic            out_d;
  logic            period_start_d;

  // Next-state: prescaler, phase counter, duty latch at wrap, output compare
  always_comb begin
    pre_d          = pre;
    phase_d        = phase;
    duty_q_d       = duty_q;
    period_start_d = 1'b0;
    tick           = (pre == PW'(PRESCALE - 1));
    wrap           = tick && (phase == BITS'(MAX - 1));
    out_d          = (phase < duty_q);

    if (tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre + PW'(1);
    end

    if (wrap) begin
      phase_d        = '0;
      duty_q_d       = duty;
      period_start_d = 1'b1;
    end else if (tick) begin
      phase_d = phase + BITS'(1);
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre          <= '0;
      phase        <= '0;
      duty_q       <= '0;
      out          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre          <= pre_d;
      phase        <= phase_d;
      duty_q       <= duty_q_d;
      out          <= out_d;
      period_start <= period_start_d;
    end
  end

endmodule

// File: tb/tb_breath_pwm.sv
// Directed testbench for breath_pwm: one PRESCALE=1 instance and one PRESCALE=4 instance.
module tb_breath_pwm;

  logic       clk = 1'b0;
  logic       rst4;
  logic       rstp;
  logic [3:0] duty4;
  logic [3:0] dutyp;
  logic       out4;
  logic       ps4;
  logic       outp;
  logic       psp;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  breath_pwm #(.BITS(4), .PRESCALE(1)) u4 (
    .clk(clk), .reset(rst4), .duty(duty4), .out(out4), .period_start(ps4)
  );

  breath_pwm #(.BITS(4), .PRESCALE(4)) up (
    .clk(clk), .reset(rstp), .duty(dutyp), .out(outp), .period_start(psp)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset the PRESCALE=1 instance; the next rising edge is edge 1
  task automatic reset4(input logic [3:0] d);
    rst4  = 1'b1;
    duty4 = d;
    step();
    rst4  = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_ps;
    rst4  = 1'b1;
    duty4 = 4'd9;
    step();
    step();
    vectors++;
    if (out4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got %b exp 0", out4);
    end
    vectors++;
    if (ps4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ps got %b exp 0", ps4);
    end
    rst4 = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      step();
      if (n == 16) begin
        vectors++;
        if (out4 !== 1'b1) begin
          errors++;
          $display("FAIL reset_pre_high got %b exp 1", out4);
        end
      end
    end
    // asynchronous assertion between edges
    #2 rst4 = 1'b1;
    #1;
    vectors++;
    if (out4 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_out got %b exp 0", out4);
    end
    vectors++;
    if (ps4 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_ps got %b exp 0", ps4);
    end
    rst4 = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      exp_ps = (n == 15);
      vectors++;
      if (ps4 !== exp_ps) begin
        errors++;
        $display("FAIL restart_ps n=%0d got %b exp %b", n, ps4, exp_ps);
      end
      if (n <= 15) begin
        vectors++;
        if (out4 !== 1'b0) begin
          errors++;
          $display("FAIL restart_out n=%0d got %b exp 0", n, out4);
        end
      end
    end
  endtask

  task automatic test_nominal();
    logic exp_out;
    logic exp_ps;
    reset4(4'd5);
    for (int n = 1; n <= 50; n++) begin
      step();
      exp_ps  = (n % 15 == 0);
      exp_out = (n >= 16) && (((n - 1) % 15) < 5);
      vectors++;
      if (ps4 !== exp_ps) begin
        errors++;
        $display("FAIL nominal_ps n=%0d got %b exp %b", n, ps4, exp_ps);
      end
      vectors++;
      if (out4 !== exp_out) begin
        errors++;
        $display("FAIL nominal_out n=%0d got %b exp %b", n, out4, exp_out);
      end
    end
  endtask

  task automatic test_extremes();
    int   highs;
    logic exp_out;
    reset4(4'd0);
    highs = 0;
    for (int n = 1; n <= 45; n++) begin
      step();
      if (out4 === 1'b1) highs++;
    end
    vectors++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL duty0_highs got %0d exp 0", highs);
    end
    reset4(4'd15);
    for (int n = 1; n <= 60; n++) begin
      step();
      exp_out = (n >= 16);
      vectors++;
      if (out4 !== exp_out) begin
        errors++;
        $display("FAIL duty15_out n=%0d got %b exp %b", n, out4, exp_out);
      end
    end
  endtask

  task automatic test_midchange();
    int highs;
    reset4(4'd3);
    highs = 0;
    for (int n = 1; n <= 45; n++) begin
      step();
      if (n == 20) duty4 = 4'd12;
      if (out4 === 1'b1) highs++;
      if (n == 15 || n == 30 || n == 45) begin
        vectors++;
        if (highs !== ((n == 15) ? 0 : (n == 30) ? 3 : 12)) begin
          errors++;
          $display("FAIL midchange_highs period_end=%0d got %0d exp %0d", n, highs,
                   (n == 15) ? 0 : (n == 30) ? 3 : 12);
        end
        highs = 0;
      end
    end
  endtask

  task automatic test_prescale();
    logic exp_out;
    logic exp_ps;
    int   highs;
    rstp  = 1'b1;
    dutyp = 4'd2;
    step();
    rstp  = 1'b0;
    highs = 0;
    for (int n = 1; n <= 130; n++) begin
      step();
      exp_ps  = (n % 60 == 0);
      exp_out = (n >= 61) && (((n - 1) % 60) < 8);
      vectors++;
      if (psp !== exp_ps) begin
        errors++;
        $display("FAIL prescale_ps n=%0d got %b exp %b", n, psp, exp_ps);
      end
      vectors++;
      if (outp !== exp_out) begin
        errors++;
        $display("FAIL prescale_out n=%0d got %b exp %b", n, outp, exp_out);
      end
      if (outp === 1'b1) highs++;
      if (n == 120) begin
        vectors++;
        if (highs !== 8) begin
          errors++;
          $display("FAIL prescale_highs got %0d exp 8", highs);
        end
      end
    end
    rstp = 1'b1;
  endtask

  // Bench-side up/down counter feeds duty; each period's high time must equal
  // the counter value present at the preceding wrap edge.
  task automatic test_counter();
    logic [3:0] cnt;
    logic       dir_up;
    logic [3:0] at_edge;
    logic [3:0] latched;
    int         highs;
    cnt    = 4'd0;
    dir_up = 1'b1;
    reset4(cnt);
    latched = 4'd0;
    highs   = 0;
    for (int n = 1; n <= 165; n++) begin
      at_edge = duty4;
      step();
      if (out4 === 1'b1) highs++;
      if (n % 15 == 0) begin
        if (n >= 30) begin
          vectors++;
          if (highs !== int'(latched)) begin
            errors++;
            $display("FAIL counter_highs period_end=%0d got %0d exp %0d", n, highs, latched);
          end
        end
        latched = at_edge;
        highs   = 0;
      end
      if (n % 4 == 0) begin
        if (dir_up && cnt == 4'd15) dir_up = 1'b0;
        else if (!dir_up && cnt == 4'd0) dir_up = 1'b1;
        cnt   = dir_up ? cnt + 4'd1 : cnt - 4'd1;
        duty4 = cnt;
      end
    end
  endtask

  initial begin
    rst4  = 1'b1;
    rstp  = 1'b1;
    duty4 = 4'd0;
    dutyp = 4'd0;
    test_reset();
    test_nominal();
    test_extremes();
    test_midchange();
    test_prescale();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
